shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one 32-bit logical-left barrel shifter (`sll`) among NREQ requesters. Each requester submits an operand plus shift amount through a valid/ready handshake. The block grants one requester per cycle, drives the shared shifter, and registers the result with the winner's ID behind a valid/ready output port. It sits between ALU-side clients (e.g. address generation, immediate formatting) and the single shifter instance.

---
 rtl/shift_arbiter_pkg.sv | 19 +
 rtl/sll.sv | 12 +
 rtl/shift_arbiter.sv | 91 +++++++++
 tb/tb_shift_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter slice: datapath widths,
// requester limit, output-register state encoding and a wrap helper.
package shift_arbiter_pkg;

   localparam int SHIFT_DW     = 32;
   localparam int SHIFT_AW     = 5;
   localparam int SHIFT_MAXREQ = 4;

   typedef enum logic {
      RES_EMPTY = 1'b0,
      RES_FULL  = 1'b1
   } res_state_t;

   // Increment modulo n, used to advance the round-robin pointer.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/sll.sv
// Logical-left barrel shifter: zero fill, bits shifted past the MSB are lost.
module sll
   import shift_arbiter_pkg::*;
(
   input  logic [SHIFT_DW-1:0] data_operandA,
   input  logic [SHIFT_AW-1:0] ctrl_shiftamt,
   output logic [SHIFT_DW-1:0] data_result
);

   assign data_result = data_operandA << ctrl_shiftamt;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one sll shifter among NREQ requesters; the
// winner's shifted operand and ID are registered behind a valid/ready port.
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*SHIFT_DW-1:0] req_data,
   input  logic [NREQ*SHIFT_AW-1:0] req_shamt,
   output logic [NREQ-1:0]          req_ready,
   output logic                     res_valid,
   output logic [SHIFT_DW-1:0]      res_data,
   output logic [IDW-1:0]           res_id,
   input  logic                     res_ready
);

   res_state_t          state, next_state;
   logic [IDW-1:0]      rr_ptr;
   logic [IDW-1:0]      winner;
   logic                found;
   logic                load;
   logic                accept;
   logic [SHIFT_DW-1:0] win_data;
   logic [SHIFT_AW-1:0] win_shamt;
   logic [SHIFT_DW-1:0] shift_result;

   // Priority search starting at rr_ptr and wrapping; first valid wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   assign load      = ~res_valid | res_ready;
   assign accept    = load & found;
   assign req_ready = accept ? (NREQ'(1) << winner) : '0;

   assign win_data  = req_data[SHIFT_DW*winner +: SHIFT_DW];
   assign win_shamt = req_shamt[SHIFT_AW*winner +: SHIFT_AW];

   sll u_sll (
      .data_operandA (win_data),
      .ctrl_shiftamt (win_shamt),
      .data_result   (shift_result)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= RES_EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // A consumed result empties the register unless a new one is loaded
   // in the same cycle; without res_ready a FULL register holds.
   always_comb begin
      next_state = state;
      case (state)
         RES_EMPTY: if (accept) next_state = RES_FULL;
         RES_FULL:  if (res_ready) next_state = accept ? RES_FULL : RES_EMPTY;
         default:   next_state = RES_EMPTY;
      endcase
   end

   assign res_valid = (state == RES_FULL);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         res_data <= '0;
         res_id   <= '0;
         rr_ptr   <= '0;
      end else if (accept) begin
         res_data <= shift_result;
         res_id   <= winner;
         rr_ptr   <= IDW'(wrap_inc(int'(winner), NREQ));
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: behavioural queue-free model of the
// grant/result rules compared every cycle, plus directed literal checks.
module tb_shift_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clock;
   logic              reset_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*32-1:0] req_data;
   logic [NREQ*5-1:0] req_shamt;
   logic [NREQ-1:0]   req_ready;
   logic              res_valid;
   logic [31:0]       res_data;
   logic [IDW-1:0]    res_id;
   logic              res_ready;

   int checks = 0;
   int errors = 0;

   shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_shamt (req_shamt),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_ready (res_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model state: what the result port must hold and where the search starts.
   int           m_rr;
   logic         m_valid;
   logic [31:0]  m_data;
   int           m_id;
   logic [NREQ-1:0] pend;
   logic [31:0]  held_data  [NREQ];
   logic [4:0]   held_shamt [NREQ];

   function automatic logic [31:0] shift_ref(input logic [31:0] d, input int s);
      logic [63:0] wide;
      wide = {32'd0, d} << s;
      return wide[31:0];
   endfunction

   // Requester that must be granted this cycle, or -1 when nobody is.
   function automatic int model_grant();
      if (m_valid && !res_ready) return -1;
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] model_ready();
      int g;
      g = model_grant();
      return (g < 0) ? '0 : NREQ'(1) << g;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_rr    <= 0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_id    <= 0;
         pend    <= '0;
      end else begin
         if (model_grant() >= 0) begin
            m_valid <= 1'b1;
            m_data  <= shift_ref(req_data[32*model_grant() +: 32],
                                 int'(req_shamt[5*model_grant() +: 5]));
            m_id    <= model_grant();
            m_rr    <= (model_grant() + 1) % NREQ;
         end else if (res_ready) begin
            m_valid <= 1'b0;
         end
         for (int i = 0; i < NREQ; i++) begin
            pend[i]       <= req_valid[i] && (i != model_grant());
            held_data[i]  <= req_data[32*i +: 32];
            held_shamt[i] <= req_shamt[5*i +: 5];
         end
      end
   end

   // Compare on the falling edge, well away from the active edge.
   always @(negedge clock) begin
      if (reset_n) begin
         check_output("req_ready", 32'(req_ready), 32'(model_ready()));
         check_output("res_valid", 32'(res_valid), 32'(m_valid));
         if (m_valid) begin
            check_output("res_data", res_data, m_data);
            check_output("res_id", 32'(res_id), 32'(m_id));
         end
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
               check_output("req_hold_valid", 32'(req_valid[i]), 32'd1);
               check_output("req_hold_data", req_data[32*i +: 32], held_data[i]);
               check_output("req_hold_shamt", 32'(req_shamt[5*i +: 5]), 32'(held_shamt[i]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input int r, input logic [31:0] d, input logic [4:0] s);
      req_valid[r]           = 1'b1;
      req_data[32*r +: 32]   = d;
      req_shamt[5*r +: 5]    = s;
   endtask

   // Keeps every requester valid until it is granted, in order 0..3.
   task automatic drain_all();
      for (int k = 0; k < NREQ; k++) begin
         tick();
         req_valid[k] = 1'b0;
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_shamt = '0;
      res_ready = 1'b1;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      check_output("reset_res_valid", 32'(res_valid), 32'd0);
      check_output("reset_res_data", res_data, 32'd0);
      check_output("reset_req_ready", 32'(req_ready), 32'd0);
      tick();

      // Single request, shamt 31 keeps only bit 0 at bit 31.
      apply_stimulus(2, 32'h0000_0001, 5'd31);
      #1;
      check_output("single_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      check_output("single_data", res_data, 32'h8000_0000);
      check_output("single_id", 32'(res_id), 32'd2);

      // Pointer now 3; only req 1 valid wins and pointer moves to 2.
      apply_stimulus(1, 32'h0000_0010, 5'd1);
      #1;
      check_output("ptr_ready", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      check_output("ptr_data", res_data, 32'h0000_0020);
      tick();
      apply_stimulus(2, 32'h0000_0003, 5'd2);
      apply_stimulus(3, 32'h0000_0005, 5'd3);
      #1;
      check_output("ptr_hold_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid[2] = 1'b0;
      tick();
      req_valid[3] = 1'b0;
      tick();

      // All four continuously valid: strict 0,1,2,3 rotation, one per cycle.
      for (int r = 0; r < NREQ; r++) apply_stimulus(r, 32'h1111_1111 * (r + 1), 5'(r * 3));
      for (int k = 0; k < 8; k++) begin
         #1;
         check_output("rr_ready", 32'(req_ready), 32'(1 << (k % NREQ)));
         tick();
         check_output("rr_id", 32'(res_id), 32'(k % NREQ));
         if (k >= 4) req_valid[k - 4] = 1'b0;
      end
      tick();

      // Backpressure: held result must not move and req 1 must wait.
      res_ready = 1'b0;
      apply_stimulus(0, 32'h0000_000A, 5'd0);
      tick();
      req_valid[0] = 1'b0;
      apply_stimulus(1, 32'hFFFF_FFFF, 5'd4);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_output("bp_ready", 32'(req_ready), 32'd0);
         check_output("bp_held_data", res_data, 32'h0000_000A);
         tick();
      end
      res_ready = 1'b1;
      #1;
      check_output("bp_release_ready", 32'(req_ready), 32'b0010);
      tick();
      req_valid[1] = 1'b0;
      check_output("bp_release_data", res_data, 32'hFFFF_FFF0);
      check_output("bp_release_id", 32'(res_id), 32'd1);
      tick();

      // Shift sweep over every amount, rotating the requester.
      for (int s = 0; s < 32; s++) begin
         apply_stimulus(s % NREQ, (s == 0) ? 32'h1234_5678 : $urandom, 5'(s));
         tick();
         req_valid = '0;
         if (s == 0) check_output("shamt0_data", res_data, 32'h1234_5678);
      end
      tick();

      // Asynchronous reset while a result is held.
      res_ready = 1'b0;
      apply_stimulus(3, 32'h0000_0055, 5'd2);
      tick();
      req_valid = '0;
      check_output("pre_reset_data", res_data, 32'h0000_0154);
      #1;
      reset_n = 1'b0;
      #1;
      check_output("async_res_valid", 32'(res_valid), 32'd0);
      check_output("async_res_data", res_data, 32'd0);
      check_output("async_res_id", 32'(res_id), 32'd0);
      tick();
      reset_n   = 1'b1;
      res_ready = 1'b1;
      for (int r = 0; r < NREQ; r++) apply_stimulus(r, 32'hC0DE_0000 + r, 5'd1);
      #1;
      check_output("post_reset_ready", 32'(req_ready), 32'b0001);
      drain_all();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
